// File: rtl/prog_loader_pkg.sv
// Shared types for the program loader: FSM state encoding and default geometry.
package prog_loader_pkg;
  localparam int ADDR_W_DEF = 6;

  typedef enum logic [2:0] {HDR, ASM, WR, CHK, DONE, ERROR} state_t;
endpackage

// File: rtl/prog_loader_byte_packer.sv
// Little-endian 4-byte to 32-bit word assembler; the byte index selects the lane written.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        last
);
  logic [1:0] idx;

  assign last = load && (idx == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      word <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (load) begin
      idx <= idx + 2'd1;
      for (int b = 0; b < 4; b++)
        if (idx == 2'(b)) word[b*8 +: 8] <= byte_in;
    end
  end
endmodule

// File: rtl/prog_loader.sv
// Serial program loader: header byte N, then 4N little-endian bytes written as N words.
// Define PROG_LOADER_CHECKSUM_EN to append an XOR checksum byte checked before DONE.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);
  // Counter must hold both 2^ADDR_W (header 0) and any 8-bit header value.
  localparam int CNT_W = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t WR_FIN = CHK;
`else
  localparam state_t WR_FIN = DONE;
`endif

  state_t            state, nxt;
  logic              armed, fire, last;
  logic [CNT_W-1:0]  rem, hdr_n;
  logic [ADDR_W-1:0] addr;

  // armed keeps byte_ready low until the first edge after reset release
  assign byte_ready = armed && (state == HDR || state == ASM || state == CHK);
  assign fire       = byte_valid && byte_ready;
  assign hdr_n      = (byte_in == 8'd0) ? (CNT_W'(1) << ADDR_W)
                                        : {{(CNT_W-8){1'b0}}, byte_in};

  byte_packer u_pack (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == HDR),
    .load    (fire && state == ASM),
    .byte_in (byte_in),
    .word    (wr_data),
    .last    (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HDR;
      armed <= 1'b0;
      rem   <= '0;
      addr  <= '0;
    end else begin
      state <= nxt;
      armed <= 1'b1;
      if (state == HDR && fire) begin
        rem  <= hdr_n;
        addr <= '0;
      end else if (state == WR) begin
        rem  <= rem - CNT_W'(1);
        addr <= addr + ADDR_W'(1);
      end
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      csum <= '0;
    else if (state == HDR)        csum <= '0;
    else if (state == ASM && fire) csum <= csum ^ byte_in;
  end
`endif

  always_comb begin
    nxt = state;
    case (state)
      HDR:  if (fire) nxt = ASM;
      ASM:  if (last) nxt = WR;
      WR:   nxt = (rem == CNT_W'(1)) ? WR_FIN : ASM;
`ifdef PROG_LOADER_CHECKSUM_EN
      CHK:  if (fire) nxt = (byte_in == csum) ? DONE : ERROR;
      ERROR: if (start) nxt = HDR;
`endif
      DONE: if (start) nxt = HDR;
      default: nxt = HDR;
    endcase
  end

  assign wr_en   = (state == WR);
  assign wr_addr = addr;
  assign cpu_rst = (state != DONE);
  assign done    = (state == DONE);
`ifdef PROG_LOADER_CHECKSUM_EN
  assign error   = (state == ERROR);
`else
  assign error   = 1'b0;
`endif
endmodule
